// File: rtl/fir_window_feeder_pkg.sv
// fir_pkg: shared types and constants for the 2D FIR window feeder.
package fir_pkg;

  localparam int unsigned TAPS      = 9;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned RING_ROWS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_TC,
    ST_FILL,
    ST_EMIT,
    ST_WAIT_CORE,
    ST_DONE
  } state_t;

  // Row/column offset of tap k relative to the centre pixel.
  localparam logic signed [1:0] TAP_ROW_OFF [TAPS] = '{
    -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1
  };
  localparam logic signed [1:0] TAP_COL_OFF [TAPS] = '{
    -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1
  };

  // Modulo-3 ring slot stepping.
  function automatic logic [1:0] slot_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] slot_prev(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

endpackage

// File: rtl/fir_window_feeder_line_ring.sv
// fir_line_ring: three image rows of IMG_W pixels each, one write port,
// combinational read port. Contents are not reset.
module fir_line_ring
  import fir_pkg::*;
#(
  parameter int N     = 24,
  parameter int IMG_W = 32
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [1:0]               i_wr_row,
  input  logic [$clog2(IMG_W)-1:0] i_wr_col,
  input  logic [N-1:0]             i_wr_data,
  input  logic [1:0]               i_rd_row,
  input  logic [$clog2(IMG_W)-1:0] i_rd_col,
  output logic [N-1:0]             o_rd_data
);

  logic [N-1:0] r_mem [RING_ROWS][IMG_W];

  // Store the incoming pixel at its ring slot / column.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_row][i_wr_col] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_row][i_rd_col];

endmodule

// File: rtl/fir_window_feeder.sv
// fir_window_feeder: buffers three raster rows and, per output pixel, emits a
// 9-tap 3x3 window burst to the FIR core; replays coefficients at frame start.
// Build option: BORDER_REPLICATE_EN selects edge replication for out-of-image
// taps; when undefined those taps are driven as zero.
module fir_window_feeder
  import fir_pkg::*;
#(
  parameter int N     = 24,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         coef_wr,
  input  logic [3:0]   coef_addr,
  input  logic [N-1:0] coef_in,
  input  logic [N-1:0] pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         out_tc_set,
  input  logic         core_done,
  output logic         busy,
  output logic         frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_H);
  localparam logic [3:0]    K_LAST   = 4'(TAPS - 1);
`ifdef BORDER_REPLICATE_EN
  localparam bit ZERO_PAD = 1'b0;
`else
  localparam bit ZERO_PAD = 1'b1;
`endif

  state_t          r_state, w_state_nx;
  logic [N-1:0]    r_coef [TAPS];
  logic [3:0]      r_k;
  logic [RW-1:0]   r_row, r_wr_row;
  logic [CW-1:0]   r_col, r_wr_col;
  logic [1:0]      r_cslot, r_wslot;
  logic            w_xfer, w_win_ready, w_last_pix, w_adv, w_frame_start;
  logic signed [1:0] w_dr, w_dc;
  logic            w_oob;
  logic [1:0]      w_rd_slot;
  logic [CW-1:0]   w_rd_col;
  logic [N-1:0]    w_rd_data, w_tap;

  assign busy          = (r_state != ST_IDLE);
  assign frame_done    = (r_state == ST_DONE);
  assign w_frame_start = (r_state == ST_IDLE) && start;
  assign pix_ready     = busy && (r_state != ST_LOAD_TC) && (r_wr_row < ROW_END)
                         && (r_wr_row <= r_row + RW'(1));
  assign w_xfer        = pix_valid && pix_ready;
  assign w_win_ready   = (r_wr_row > r_row + RW'(1))
                         || ((r_row == ROW_LAST) && (r_wr_row == ROW_END));
  assign w_last_pix    = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_adv         = (r_state == ST_WAIT_CORE) && core_done && !w_last_pix;

  fir_line_ring #(.N(N), .IMG_W(IMG_W)) u_ring (
    .clk       (clk),
    .i_wr_en   (w_xfer),
    .i_wr_row  (r_wslot),
    .i_wr_col  (r_wr_col),
    .i_wr_data (pix_in),
    .i_rd_row  (w_rd_slot),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state decode.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_state_nx = ST_LOAD_TC;
      ST_LOAD_TC:   if (r_k == K_LAST) w_state_nx = ST_FILL;
      ST_FILL:      if (w_win_ready) w_state_nx = ST_EMIT;
      ST_EMIT:      if (r_k == K_LAST) w_state_nx = ST_WAIT_CORE;
      ST_WAIT_CORE: if (core_done) w_state_nx = w_last_pix ? ST_DONE : ST_FILL;
      ST_DONE:      w_state_nx = ST_IDLE;
      default:      w_state_nx = ST_IDLE;
    endcase
  end

  // Coefficient bank: writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if ((r_state == ST_IDLE) && coef_wr && (coef_addr < 4'(TAPS))) begin
      r_coef[coef_addr] <= coef_in;
    end
  end

  // Tap counter shared by the coefficient replay and window bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_k <= '0;
    else if ((r_state == ST_LOAD_TC) || (r_state == ST_EMIT))
      r_k <= (r_k == K_LAST) ? '0 : r_k + 4'd1;
    else
      r_k <= '0;
  end

  // Write pointer: raster position of the next accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_row <= '0;
      r_wr_col <= '0;
      r_wslot  <= '0;
    end else if (w_frame_start) begin
      r_wr_row <= '0;
      r_wr_col <= '0;
      r_wslot  <= '0;
    end else if (w_xfer) begin
      if (r_wr_col == COL_LAST) begin
        r_wr_col <= '0;
        r_wr_row <= r_wr_row + RW'(1);
        r_wslot  <= slot_next(r_wslot);
      end else begin
        r_wr_col <= r_wr_col + CW'(1);
      end
    end
  end

  // Centre pointer: advances on each core completion, stays put on the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row   <= '0;
      r_col   <= '0;
      r_cslot <= '0;
    end else if (w_frame_start) begin
      r_row   <= '0;
      r_col   <= '0;
      r_cslot <= '0;
    end else if (w_adv) begin
      if (r_col == COL_LAST) begin
        r_col   <= '0;
        r_row   <= r_row + RW'(1);
        r_cslot <= slot_next(r_cslot);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Window addressing: read address is clamped into the image, out-of-image
  // taps are flagged so zero padding can override the clamped read.
  always_comb begin
    w_dr      = TAP_ROW_OFF[r_k];
    w_dc      = TAP_COL_OFF[r_k];
    w_oob     = 1'b0;
    w_rd_slot = r_cslot;
    w_rd_col  = r_col;
    if (w_dr == -2'sd1) begin
      if (r_row == '0) w_oob = 1'b1;
      else             w_rd_slot = slot_prev(r_cslot);
    end else if (w_dr == 2'sd1) begin
      if (r_row == ROW_LAST) w_oob = 1'b1;
      else                   w_rd_slot = slot_next(r_cslot);
    end
    if (w_dc == -2'sd1) begin
      if (r_col == '0) w_oob = 1'b1;
      else             w_rd_col = r_col - CW'(1);
    end else if (w_dc == 2'sd1) begin
      if (r_col == COL_LAST) w_oob = 1'b1;
      else                   w_rd_col = r_col + CW'(1);
    end
    w_tap = (ZERO_PAD && w_oob) ? '0 : w_rd_data;
  end

  // Registered output stage to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_tc_set <= 1'b0;
      out_data   <= '0;
    end else begin
      case (r_state)
        ST_LOAD_TC: begin
          out_valid  <= 1'b1;
          out_tc_set <= 1'b1;
          out_data   <= r_coef[r_k];
        end
        ST_EMIT: begin
          out_valid  <= 1'b1;
          out_tc_set <= 1'b0;
          out_data   <= w_tap;
        end
        default: begin
          out_valid  <= 1'b0;
          out_tc_set <= 1'b0;
          out_data   <= '0;
        end
      endcase
    end
  end

endmodule
